// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: operand forwarding across FWD_STAGES sources, a
// per-register busy scoreboard for multi-cycle producers, the decode stall,
// and a saturating count of stalled cycles.

// hs_reg_cnt: busy down-counter for one architectural register.
module hs_reg_cnt #(
  parameter int LAT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [LAT_W-1:0] load_val_i,
  output logic             busy_o
);

  logic [LAT_W-1:0] cnt_q, cnt_d;

  // Count down while nonzero; a fresh issue overrides the decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != '0) cnt_d = cnt_q - LAT_W'(1);
    if (load_i)      cnt_d = load_val_i;
  end

  // Counter register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign busy_o = (cnt_q != '0);

endmodule

module hazard_scoreboard #(
  parameter int ADDR_W     = 5,
  parameter int FWD_STAGES = 2,
  parameter int LAT_W      = 4,
  parameter int SEL_W      = $clog2(FWD_STAGES + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         id_valid,
  input  logic [ADDR_W-1:0]            id_rs1,
  input  logic [ADDR_W-1:0]            id_rs2,
  input  logic [ADDR_W-1:0]            id_rd,
  input  logic                         id_we,
  input  logic [ADDR_W-1:0]            ex_rs1,
  input  logic [ADDR_W-1:0]            ex_rs2,
  input  logic                         ex_we,
  input  logic                         ex_is_load,
  input  logic [ADDR_W-1:0]            ex_rd,
  input  logic [FWD_STAGES-1:0]        stage_we,
  input  logic [FWD_STAGES*ADDR_W-1:0] stage_rd,
  input  logic                         mc_issue,
  input  logic [ADDR_W-1:0]            mc_rd,
  input  logic [LAT_W-1:0]             mc_lat,
  output logic [SEL_W-1:0]             fwd_a,
  output logic [SEL_W-1:0]             fwd_b,
  output logic                         stall,
  output logic [(2**ADDR_W)-1:0]       busy_vec,
  output logic [15:0]                  stall_cnt
);

  localparam int NREGS = 2 ** ADDR_W;

  // Per-stage view of the flat destination bus; stage 0 is the youngest.
  logic [FWD_STAGES-1:0][ADDR_W-1:0] stage_rd_a;
  assign stage_rd_a = stage_rd;

  // Forward select: scan oldest to youngest so the youngest match lands last.
  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
    for (int k = FWD_STAGES - 1; k >= 0; k--) begin
      if (stage_we[k] && (stage_rd_a[k] != '0)) begin
        if (stage_rd_a[k] == ex_rs1) fwd_a = SEL_W'(k + 1);
        if (stage_rd_a[k] == ex_rs2) fwd_b = SEL_W'(k + 1);
      end
    end
  end

  // A zero latency still has to cover at least one cycle.
  logic [LAT_W-1:0] mc_load_val;
  assign mc_load_val = (mc_lat == '0) ? LAT_W'(1) : mc_lat;

  // x0 has no counter: it is never busy, and issues to it are dropped.
  assign busy_vec[0] = 1'b0;

  for (genvar r = 1; r < NREGS; r++) begin : g_reg
    hs_reg_cnt #(.LAT_W(LAT_W)) u_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (mc_issue && (mc_rd == ADDR_W'(r))),
      .load_val_i (mc_load_val),
      .busy_o     (busy_vec[r])
    );
  end

  // Decode hazards: load-use on the EX result, RAW or WAW on a busy register.
  logic load_use, raw_busy, waw_busy;

  always_comb begin
    load_use = ex_is_load && ex_we && (ex_rd != '0) &&
               ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    raw_busy = ((id_rs1 != '0) && busy_vec[id_rs1]) ||
               ((id_rs2 != '0) && busy_vec[id_rs2]);
    waw_busy = id_we && (id_rd != '0) && busy_vec[id_rd];
    stall    = id_valid && (load_use || raw_busy || waw_busy);
  end

  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Stall-cycle counter, saturating at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  // Performance counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: forwarding priority, load-use stall,
// scoreboard timing, async reset, counter saturation, FWD_STAGES 1 and 4.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_we, ex_we, ex_is_load, mc_issue;
  logic [4:0]  id_rs1, id_rs2, id_rd, ex_rs1, ex_rs2, ex_rd, mc_rd;
  logic [3:0]  mc_lat;
  logic [1:0]  stage_we;
  logic [9:0]  stage_rd;
  logic [1:0]  fwd_a, fwd_b;
  logic        stall;
  logic [31:0] busy_vec;
  logic [15:0] stall_cnt;

  // FWD_STAGES = 1 and 4 variants share everything but the stage buses.
  logic        stage_we1;
  logic [4:0]  stage_rd1;
  logic        fwd_a1, fwd_b1, stall1;
  logic [31:0] busy_vec1;
  logic [15:0] stall_cnt1;
  logic [3:0]  stage_we4;
  logic [19:0] stage_rd4;
  logic [2:0]  fwd_a4, fwd_b4;
  logic        stall4;
  logic [31:0] busy_vec4;
  logic [15:0] stall_cnt4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_we(id_we), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_we(ex_we),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .stage_we(stage_we), .stage_rd(stage_rd),
    .mc_issue(mc_issue), .mc_rd(mc_rd), .mc_lat(mc_lat), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall(stall), .busy_vec(busy_vec), .stall_cnt(stall_cnt)
  );

  hazard_scoreboard #(.FWD_STAGES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_we(id_we), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_we(ex_we),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .stage_we(stage_we1), .stage_rd(stage_rd1),
    .mc_issue(mc_issue), .mc_rd(mc_rd), .mc_lat(mc_lat), .fwd_a(fwd_a1), .fwd_b(fwd_b1),
    .stall(stall1), .busy_vec(busy_vec1), .stall_cnt(stall_cnt1)
  );

  hazard_scoreboard #(.FWD_STAGES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_we(id_we), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_we(ex_we),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .stage_we(stage_we4), .stage_rd(stage_rd4),
    .mc_issue(mc_issue), .mc_rd(mc_rd), .mc_lat(mc_lat), .fwd_a(fwd_a4), .fwd_b(fwd_b4),
    .stall(stall4), .busy_vec(busy_vec4), .stall_cnt(stall_cnt4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    {id_valid, id_we, ex_we, ex_is_load, mc_issue} = '0;
    {id_rs1, id_rs2, id_rd, ex_rs1, ex_rs2, ex_rd, mc_rd} = '0;
    mc_lat = '0; stage_we = '0; stage_rd = '0;
    stage_we1 = '0; stage_rd1 = '0; stage_we4 = '0; stage_rd4 = '0;

    // Reset state, outputs combinational during reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fwd_a", 32'(fwd_a), 32'd0);
    chk("rst_fwd_b", 32'(fwd_b), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_busy", busy_vec, 32'd0);
    chk("rst_cnt", 32'(stall_cnt), 32'd0);
    rst_n = 1'b1;
    tick();

    // Forwarding priority on the default two-stage unit
    stage_we = 2'b11; stage_rd = {5'd5, 5'd5}; ex_rs1 = 5'd5; ex_rs2 = 5'd5;
    #1;
    chk("fwd_a_young", 32'(fwd_a), 32'd1);
    chk("fwd_b_young", 32'(fwd_b), 32'd1);
    stage_we = 2'b10;
    #1;
    chk("fwd_a_old", 32'(fwd_a), 32'd2);
    ex_rs2 = 5'd6;
    #1;
    chk("fwd_b_nomatch", 32'(fwd_b), 32'd0);
    stage_we = 2'b11; stage_rd = '0; ex_rs1 = 5'd0;
    #1;
    chk("fwd_a_x0", 32'(fwd_a), 32'd0);
    stage_we = '0; ex_rs1 = '0; ex_rs2 = '0;

    // Load-use stall and the stall counter
    ex_is_load = 1'b1; ex_we = 1'b1; ex_rd = 5'd7; id_valid = 1'b1; id_rs2 = 5'd7;
    #1;
    chk("lu_stall", 32'(stall), 32'd1);
    tick();
    chk("lu_cnt", 32'(stall_cnt), 32'd1);
    ex_rd = 5'd0;
    #1;
    chk("lu_x0_nostall", 32'(stall), 32'd0);
    tick();
    chk("lu_cnt_hold", 32'(stall_cnt), 32'd1);
    {ex_is_load, ex_we} = '0; id_rs2 = '0;

    // Multi-cycle RAW: rd 9, lat 3
    id_rs1 = 5'd9; mc_issue = 1'b1; mc_rd = 5'd9; mc_lat = 4'd3;
    #1;
    chk("mc_pre_stall", 32'(stall), 32'd0);
    tick();
    mc_issue = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("mc9_busy", 32'(busy_vec[9]), 32'd1);
      chk("mc9_stall", 32'(stall), 32'd1);
      tick();
    end
    chk("mc9_free", 32'(busy_vec[9]), 32'd0);
    chk("mc9_nostall", 32'(stall), 32'd0);
    chk("mc9_cnt", 32'(stall_cnt), 32'd4);
    id_rs1 = '0;

    // Reissue to a busy register restarts it; WAW stall throughout
    id_we = 1'b1; id_rd = 5'd4; mc_issue = 1'b1; mc_rd = 5'd4; mc_lat = 4'd2;
    tick();
    chk("waw_stall0", 32'(stall), 32'd1);
    mc_lat = 4'd5;
    tick();
    mc_issue = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("re4_busy", 32'(busy_vec[4]), 32'd1);
      chk("re4_stall", 32'(stall), 32'd1);
      tick();
    end
    chk("re4_free", busy_vec, 32'd0);
    chk("re4_cnt", 32'(stall_cnt), 32'd10);
    id_we = 1'b0; id_rd = '0; id_valid = 1'b0;

    // mc_lat 0 acts as 1; mc_rd 0 ignored
    mc_issue = 1'b1; mc_rd = 5'd6; mc_lat = 4'd0;
    tick();
    mc_rd = 5'd0; mc_lat = 4'd7;
    chk("lat0_busy", busy_vec, 32'h0000_0040);
    tick();
    chk("lat0_free_x0_ignored", busy_vec, 32'd0);

    // Issue and decrement-to-zero on the same edge: issue wins
    mc_rd = 5'd6; mc_lat = 4'd1;
    tick();
    tick();
    mc_issue = 1'b0;
    chk("issue_wins", busy_vec, 32'h0000_0040);
    tick();
    chk("issue_wins_free", busy_vec, 32'd0);

    // Async reset mid-count
    id_valid = 1'b1; id_rs1 = 5'd3; mc_issue = 1'b1; mc_rd = 5'd3; mc_lat = 4'd15;
    tick();
    mc_issue = 1'b0;
    tick();
    tick();
    chk("pre_rst_cnt", 32'(stall_cnt), 32'd12);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy_vec, 32'd0);
    chk("arst_cnt", 32'(stall_cnt), 32'd0);
    chk("arst_stall", 32'(stall), 32'd0);
    #3 rst_n = 1'b1;
    tick();
    chk("post_rst_busy", busy_vec, 32'd0);
    chk("post_rst_cnt", 32'(stall_cnt), 32'd0);
    id_rs1 = '0;

    // FWD_STAGES = 4: youngest-wins sweep
    stage_we4 = 4'b1111; stage_rd4 = {5'd12, 5'd12, 5'd12, 5'd12};
    ex_rs1 = 5'd12; ex_rs2 = 5'd13;
    #1;
    chk("f4_s0", 32'(fwd_a4), 32'd1);
    chk("f4_b_none", 32'(fwd_b4), 32'd0);
    stage_we4 = 4'b1110;
    #1;
    chk("f4_s1", 32'(fwd_a4), 32'd2);
    stage_we4 = 4'b1100;
    #1;
    chk("f4_s2", 32'(fwd_a4), 32'd3);
    stage_we4 = 4'b1000;
    #1;
    chk("f4_s3", 32'(fwd_a4), 32'd4);
    stage_we4 = 4'b0000;
    #1;
    chk("f4_none", 32'(fwd_a4), 32'd0);
    stage_we4 = 4'b1111; stage_rd4 = {5'd12, 5'd13, 5'd12, 5'd12};
    #1;
    chk("f4_b_s2", 32'(fwd_b4), 32'd3);
    chk("f4_a_s0", 32'(fwd_a4), 32'd1);

    // FWD_STAGES = 1
    stage_we1 = 1'b1; stage_rd1 = 5'd12;
    #1;
    chk("f1_s0", 32'(fwd_a1), 32'd1);
    chk("f1_b_none", 32'(fwd_b1), 32'd0);
    stage_rd1 = 5'd0; ex_rs1 = 5'd0;
    #1;
    chk("f1_x0", 32'(fwd_a1), 32'd0);

    // Saturation: continuous load-use stall from a cleared counter
    ex_rs1 = '0; ex_rs2 = '0;
    ex_is_load = 1'b1; ex_we = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_valid = 1'b1;
    repeat (65534) tick();
    chk("sat_fffe", 32'(stall_cnt), 32'h0000_FFFE);
    tick();
    chk("sat_ffff", 32'(stall_cnt), 32'h0000_FFFF);
    repeat (10) tick();
    chk("sat_hold", 32'(stall_cnt), 32'h0000_FFFF);
    chk("sat_stall", 32'(stall), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
